// File: rtl/risc_v_mem_access_unit.sv
// RV32I load/store access unit: sub-word extraction with sign/zero extension,
// read-modify-write merge for SB/SH, misalignment and illegal-funct3 detection.
module risc_v_mem_access_unit #(
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] merge_q, merge_d;
  logic [31:0] rdata_q, rdata_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        write_q, write_d;
  logic        error_q, error_d;
  logic        req_err;

  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  lane,
                                               input logic [2:0]  f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'b0, b};
      3'b101:  return {16'b0, h};
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] old_word,
                                              input logic [31:0] wdata,
                                              input logic [1:0]  lane,
                                              input logic [2:0]  f3);
    logic [31:0] res;
    res = old_word;
    case (f3[1:0])
      2'b00: res[{lane, 3'b000} +: 8] = wdata[7:0];
      2'b01: begin
        if (lane[1]) res[31:16] = wdata[15:0];
        else         res[15:0]  = wdata[15:0];
      end
      default: res = wdata;
    endcase
    return res;
  endfunction

  function automatic logic access_error(input logic        wr,
                                        input logic [2:0]  f3,
                                        input logic [1:0]  lo);
    logic illegal, misaligned;
    if (wr) illegal = (f3 >= 3'd3);
    else    illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
    misaligned = ((f3[1:0] == 2'b01) && lo[0]) ||
                 ((f3[1:0] == 2'b10) && (lo != 2'b00));
    return illegal || (ALIGN_CHECK && misaligned);
  endfunction

  assign req_err = access_error(req_write, req_funct3, req_addr[1:0]);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    merge_d    = merge_q;
    rdata_d    = rdata_q;
    funct3_d   = funct3_q;
    write_d    = write_q;
    error_d    = error_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_we     = 1'b0;
    mem_wdata  = 32'b0;
    mem_addr   = {addr_q[31:2], 2'b00};
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          funct3_d = req_funct3;
          write_d  = req_write;
          error_d  = req_err;
          if (req_err) begin
            rdata_d = 32'b0;
            state_d = RESP;
          end else if (req_write && (req_funct3[1:0] == 2'b10)) begin
            state_d = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        // Sub-word stores park the old word here; loads finish straight away.
        if (write_q) begin
          merge_d = mem_rdata;
          state_d = WRITE;
        end else begin
          rdata_d = load_extract(mem_rdata, addr_q[1:0], funct3_q);
          state_d = RESP;
        end
      end
      WRITE: begin
        mem_we    = 1'b1;
        mem_wdata = store_merge(merge_q, wdata_q, addr_q[1:0], funct3_q);
        rdata_d   = 32'b0;
        state_d   = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= 32'b0;
      wdata_q  <= 32'b0;
      merge_q  <= 32'b0;
      rdata_q  <= 32'b0;
      funct3_q <= 3'b0;
      write_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      merge_q  <= merge_d;
      rdata_q  <= rdata_d;
      funct3_q <= funct3_d;
      write_q  <= write_d;
      error_q  <= error_d;
    end
  end

  assign resp_rdata = rdata_q;
  assign resp_error = error_q;

endmodule

// File: tb/tb_risc_v_mem_access_unit.sv
// Bench for risc_v_mem_access_unit: directed vector table, reset-in-RMW sequence,
// and randomized accesses checked against an arithmetic reference model.
module tb_risc_v_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem     [0:63];
  logic [31:0] ref_mem [0:63];
  logic        mem_init;
  int          we_cnt;
  logic [31:0] last_wa, last_wd;

  always #5 clk = ~clk;

  risc_v_mem_access_unit #(.ALIGN_CHECK(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] init_val(input int i);
    if (i == 4) return 32'h8899AABB;
    if (i == 8) return 32'h0;
    return 32'h1357_0000 ^ (32'h0102_0304 * i);
  endfunction

  // Word-addressed memory: combinational read, synchronous write.
  assign mem_rdata = mem[mem_addr[7:2]];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_val(i);
      we_cnt <= 0;
    end else if (mem_we) begin
      mem[mem_addr[7:2]] <= mem_wdata;
      we_cnt  <= we_cnt + 1;
      last_wa <= mem_addr;
      last_wd <= mem_wdata;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: size from funct3, byte-mask arithmetic on ref_mem.
  task automatic model(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] rd,
                       output logic er, output int lat, output int nw);
    int size, idx, sh;
    longint unsigned mask, word, v;
    logic illegal, misal;
    size    = 1 << f3[1:0];
    illegal = wr ? (f3 >= 3) : (f3 == 3 || f3 == 6 || f3 == 7);
    misal   = (size == 2 && a % 2 != 0) || (size == 4 && a % 4 != 0);
    rd = 32'h0; er = 1'b0; nw = 0; lat = 0;
    if (illegal || misal) begin
      er = 1'b1; lat = 1;
      return;
    end
    idx  = int'((a / 4) % 64);
    sh   = int'(a % 4) * 8;
    mask = (64'd1 << (8 * size)) - 64'd1;
    word = {32'h0, ref_mem[idx]};
    if (!wr) begin
      v = (word >> sh) & mask;
      if (f3 < 4 && size < 4 && v[8*size-1]) v = v | (~mask & 64'hFFFF_FFFF);
      rd  = v[31:0];
      lat = 2;
    end else begin
      v = (word & ~(mask << sh)) | (({32'h0, wd} & mask) << sh);
      ref_mem[idx] = v[31:0];
      nw  = 1;
      lat = (size == 4) ? 2 : 3;
    end
  endtask

  // req_valid stays high through the busy period; the DUT must ignore it.
  task automatic do_req(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd,
                        output logic er, output int lat, output int nw);
    int  w0;
    bit  seen;
    @(negedge clk);
    chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
    req_write = wr; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    w0 = we_cnt;
    @(posedge clk);
    rd = 32'h0; er = 1'b0; lat = 99; seen = 1'b0;
    for (int c = 1; c <= 8 && !seen; c++) begin
      @(negedge clk);
      if (resp_valid) begin
        seen = 1'b1; lat = c; rd = resp_rdata; er = resp_error;
      end
    end
    req_valid = 1'b0;
    @(negedge clk);
    chk("resp_valid_one_pulse", {31'b0, resp_valid}, 32'd0);
    nw = we_cnt - w0;
  endtask

  typedef struct {
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nw;
    logic [31:0] wa;
    logic [31:0] wd;
  } vec_t;

  vec_t vecs [19];

  initial begin
    logic [31:0] rd, erd;
    logic        er, eer;
    int          lat, nw, elat, enw, w0;
    bit          any;

    #200000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, erd;
    logic        er, eer;
    int          lat, nw, elat, enw, w0, idx;
    bit          any;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] a, wd;

    vecs[0]  = '{1'b0, 3'd0, 32'h11, 32'h0, 32'hFFFFFFAA, 1'b0, 2, 0, 32'h0, 32'h0};
    vecs[1]  = '{1'b0, 3'd4, 32'h11, 32'h0, 32'h000000AA, 1'b0, 2, 0, 32'h0, 32'h0};
    vecs[2]  = '{1'b0, 3'd1, 32'h12, 32'h0, 32'hFFFF8899, 1'b0, 2, 0, 32'h0, 32'h0};
    vecs[3]  = '{1'b0, 3'd5, 32'h12, 32'h0, 32'h00008899, 1'b0, 2, 0, 32'h0, 32'h0};
    vecs[4]  = '{1'b0, 3'd2, 32'h10, 32'h0, 32'h8899AABB, 1'b0, 2, 0, 32'h0, 32'h0};
    vecs[5]  = '{1'b1, 3'd1, 32'h12, 32'h1234CDEF, 32'h0, 1'b0, 3, 1, 32'h10, 32'hCDEFAABB};
    vecs[6]  = '{1'b0, 3'd2, 32'h10, 32'h0, 32'hCDEFAABB, 1'b0, 2, 0, 32'h0, 32'h0};
    vecs[7]  = '{1'b1, 3'd2, 32'h10, 32'h8899AABB, 32'h0, 1'b0, 2, 1, 32'h10, 32'h8899AABB};
    vecs[8]  = '{1'b1, 3'd0, 32'h13, 32'h0000005A, 32'h0, 1'b0, 3, 1, 32'h10, 32'h5A99AABB};
    vecs[9]  = '{1'b1, 3'd2, 32'h20, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1, 32'h20, 32'hDEADBEEF};
    vecs[10] = '{1'b0, 3'd2, 32'h13, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0, 32'h0};
    vecs[11] = '{1'b1, 3'd1, 32'h11, 32'hFFFFFFFF, 32'h0, 1'b1, 1, 0, 32'h0, 32'h0};
    vecs[12] = '{1'b0, 3'd3, 32'h10, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0, 32'h0};
    vecs[13] = '{1'b1, 3'd5, 32'h10, 32'hFFFFFFFF, 32'h0, 1'b1, 1, 0, 32'h0, 32'h0};
    vecs[14] = '{1'b0, 3'd2, 32'h10, 32'h0, 32'h5A99AABB, 1'b0, 2, 0, 32'h0, 32'h0};
    vecs[15] = '{1'b0, 3'd2, 32'h20, 32'h0, 32'hDEADBEEF, 1'b0, 2, 0, 32'h0, 32'h0};
    vecs[16] = '{1'b0, 3'd0, 32'h10, 32'h0, 32'hFFFFFFBB, 1'b0, 2, 0, 32'h0, 32'h0};
    vecs[17] = '{1'b0, 3'd1, 32'h10, 32'h0, 32'hFFFFAABB, 1'b0, 2, 0, 32'h0, 32'h0};
    vecs[18] = '{1'b0, 3'd4, 32'h13, 32'h0, 32'h0000005A, 1'b0, 2, 0, 32'h0, 32'h0};

    for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
    rst = 1'b1; mem_init = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'h0; req_wdata = 32'h0;
    @(posedge clk);
    #1 mem_init = 1'b0;
    @(negedge clk);
    chk("rst_req_ready",  {31'b0, req_ready},  32'd1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_resp_error", {31'b0, resp_error}, 32'd0);
    chk("rst_mem_we",     {31'b0, mem_we},     32'd0);
    chk("rst_mem_addr",   mem_addr,  32'h0);
    chk("rst_mem_wdata",  mem_wdata, 32'h0);
    rst = 1'b0;

    // Directed vectors; the model runs alongside only to keep ref_mem current.
    for (int i = 0; i < 19; i++) begin
      model(vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wdata, erd, eer, elat, enw);
      do_req(vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, er, lat, nw);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].rdata);
      chk($sformatf("vec%0d_error", i), {31'b0, er}, {31'b0, vecs[i].err});
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("vec%0d_writes", i), nw, vecs[i].nw);
      if (vecs[i].nw == 1) begin
        chk($sformatf("vec%0d_waddr", i), last_wa, vecs[i].wa);
        chk($sformatf("vec%0d_wdata", i), last_wd, vecs[i].wd);
      end
    end

    // SB interrupted by reset while in READ: no write, no response.
    @(negedge clk);
    req_write = 1'b1; req_funct3 = 3'd0; req_addr = 32'h11; req_wdata = 32'h77;
    req_valid = 1'b1;
    w0 = we_cnt;
    @(posedge clk);
    @(negedge clk);
    chk("rmw_busy_ready", {31'b0, req_ready}, 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("midrst_req_ready",  {31'b0, req_ready},  32'd1);
    chk("midrst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("midrst_mem_we",     {31'b0, mem_we},     32'd0);
    chk("midrst_mem_addr",   mem_addr, 32'h0);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    any = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (resp_valid) any = 1'b1;
    end
    chk("midrst_no_resp", {31'b0, any}, 32'd0);
    chk("midrst_no_write", we_cnt - w0, 32'd0);
    chk("midrst_word_kept", mem[4], ref_mem[4]);
    chk("midrst_ready_after", {31'b0, req_ready}, 32'd1);

    // Randomized accesses against the reference model.
    for (int n = 0; n < 60; n++) begin
      wr = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = 32'($urandom_range(0, 255));
      wd = $urandom;
      model(wr, f3, a, wd, erd, eer, elat, enw);
      do_req(wr, f3, a, wd, rd, er, lat, nw);
      chk($sformatf("rnd%0d_rdata", n), rd, erd);
      chk($sformatf("rnd%0d_error", n), {31'b0, er}, {31'b0, eer});
      chk($sformatf("rnd%0d_latency", n), lat, elat);
      chk($sformatf("rnd%0d_writes", n), nw, enw);
      idx = int'((a / 4) % 64);
      chk($sformatf("rnd%0d_memword", n), mem[idx], ref_mem[idx]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/risc_v_mem_access_unit.md
Name: risc_v_mem_access_unit

Overview:
Load/store access unit between the multi-cycle RISC-V datapath and the word-addressed unified memory, which has combinational read, word index addr>>2, and synchronous write on we.
Executes RV32I LB/LH/LW/LBU/LHU/SB/SH/SW: byte/halfword extraction with sign/zero extension on loads, read-modify-write merge on sub-word stores.
Valid/ready request handshake from the controller; single-cycle response pulse back.
Flags misaligned accesses and illegal funct3; these never touch memory.

Parameters:
ALIGN_CHECK, 1, 1 = misaligned halfword/word access returns resp_error without a memory access; 0 = low address bits ignored (halfword uses addr[1], word uses the aligned word).

Ports:
clk  in  1  clock
rst  in  1  reset
req_valid  in  1  access request
req_ready  out  1  unit idle, accepts a request
req_write  in  1  1 = store, 0 = load
req_funct3  in  3  RV32I funct3 of the load/store
req_addr  in  32  byte address
req_wdata  in  32  store data (rs2)
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  load result, extended; 0 for stores and errors
resp_error  out  1  misaligned or illegal funct3; valid with resp_valid
mem_addr  out  32  to memory addr, always {a[31:2],2'b00}
mem_wdata  out  32  to memory din
mem_we  out  1  to memory we
mem_rdata  in  32  from memory dout (combinational)

Behaviour:
- Reset rst: asynchronous, active-high; clock clk.
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_error=0, mem_we=0, mem_addr=0, mem_wdata=0. All internal latches cleared.
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE:
  - req_ready=1. Request is accepted on a clk edge with req_valid=1.
  - On accept, latch addr, funct3, wdata and write.
  - Next state: error -> RESP; load -> READ; SW -> WRITE; SB/SH -> READ.
- Error conditions:
  - Illegal funct3: load funct3 in {3,6,7}; store funct3 >= 3.
  - Misaligned (ALIGN_CHECK=1): LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0.
- READ: mem_addr = aligned latched address; mem_rdata sampled at the end of the cycle.
  - Load: lane selected by addr[1:0] (byte) or addr[1] (half), little-endian. LB/LH sign-extend, LBU/LHU zero-extend. Result registered into resp_rdata. Next state RESP.
  - SB/SH: old word registered into a merge register. Next state WRITE.
- WRITE: mem_we=1 for exactly this one cycle; mem_addr aligned.
  - mem_wdata: SW = wdata. SB = old word with byte lane addr[1:0] replaced by wdata[7:0]. SH = old word with half lane addr[1] replaced by wdata[15:0].
  - Next state RESP.
- RESP: resp_valid=1 for one cycle; resp_rdata/resp_error held valid during that cycle. Next state IDLE.
  - There is no response backpressure; the controller must sample the response in the RESP cycle.
- mem_we is 0 in every state except WRITE. Each store writes memory exactly once; a load or an error never writes.
- Latency, in cycles from the accept edge to resp_valid high:
  - load: 2
  - SW: 2
  - SB/SH: 3
  - error: 1
- Outside the RESP cycle: resp_rdata retains its last value; resp_error is cleared on the next accept.
- req_valid outside IDLE is ignored; no queueing.
- Reset mid-operation: immediate return to IDLE, all outputs cleared, no response is generated.
  - A write already clocked into memory in WRITE stays.
  - rst asserted during READ of an RMW guarantees no write occurs.
- Store to the same word as the following load: the load observes the new data, because the write completes before RESP.

Test Plan:
- Word 0x10 = 0x8899AABB. LB addr 0x11 -> resp_rdata 0xFFFFFFAA. LBU 0x11 -> 0x000000AA. Both have resp_valid 2 cycles after accept and mem_we never high.
- Same word. LH 0x12 -> 0xFFFF8899; LHU 0x12 -> 0x00008899; LW 0x10 -> 0x8899AABB.
- SH addr 0x12, wdata 0x1234CDEF -> exactly one mem_we pulse with mem_wdata 0xCDEFAABB at mem_addr 0x10. resp_valid 3 cycles after accept; a subsequent LW 0x10 returns 0xCDEFAABB.
- SB addr 0x13, wdata 0x000000 5A on word 0x8899AABB -> write 0x5A99AABB. SW 0x20 with 0xDEADBEEF -> write 0xDEADBEEF, 2-cycle latency.
- LW 0x13 and SH 0x11 (ALIGN_CHECK=1); LB with funct3=3 -> each gives resp_error=1 and resp_rdata=0 one cycle after accept. No mem_we; memory unchanged.
- SB accepted, then rst pulsed during READ -> no mem_we, no resp_valid, req_ready=1 after reset. Memory word unchanged; req_valid held during the busy period is ignored.
